// File: rtl/ibex_pkg.sv
// ibex_pkg: definitions shared between the dummy instruction inserter and the
// retire-side dummy instruction checker.
//   - dummy_instr_e       : the four dummy instruction kinds
//   - DUMMY_OPCODE        : major opcode of every dummy (OP, R-type)
//   - DUMMY_*_FUNCT7/3    : funct fields per dummy kind
//   - dummy_instr_funct() : {funct7, funct3} for a dummy kind (inserter side)
//   - dummy_instr_legal() : true when an encoding is a legal dummy (checker side)
package ibex_pkg;

  typedef enum logic [1:0] {
    DUMMY_ADD = 2'b00,
    DUMMY_MUL = 2'b01,
    DUMMY_DIV = 2'b10,
    DUMMY_AND = 2'b11
  } dummy_instr_e;

  localparam logic [6:0] DUMMY_OPCODE     = 7'h33;

  localparam logic [6:0] DUMMY_ADD_FUNCT7 = 7'h00;
  localparam logic [2:0] DUMMY_ADD_FUNCT3 = 3'b000;
  localparam logic [6:0] DUMMY_MUL_FUNCT7 = 7'h01;
  localparam logic [2:0] DUMMY_MUL_FUNCT3 = 3'b000;
  localparam logic [6:0] DUMMY_DIV_FUNCT7 = 7'h01;
  localparam logic [2:0] DUMMY_DIV_FUNCT3 = 3'b100;
  localparam logic [6:0] DUMMY_AND_FUNCT7 = 7'h00;
  localparam logic [2:0] DUMMY_AND_FUNCT3 = 3'b111;

  // {funct7, funct3} the inserter places into a dummy of the given kind.
  function automatic logic [9:0] dummy_instr_funct(input dummy_instr_e kind);
    logic [9:0] f;
    case (kind)
      DUMMY_ADD: f = {DUMMY_ADD_FUNCT7, DUMMY_ADD_FUNCT3};
      DUMMY_MUL: f = {DUMMY_MUL_FUNCT7, DUMMY_MUL_FUNCT3};
      DUMMY_DIV: f = {DUMMY_DIV_FUNCT7, DUMMY_DIV_FUNCT3};
      default:   f = {DUMMY_AND_FUNCT7, DUMMY_AND_FUNCT3};
    endcase
    return f;
  endfunction

  // Dummies always write x0 and use the OP opcode; rs1/rs2 are random.
  function automatic logic dummy_instr_legal(input logic [31:0] instr);
    logic [9:0] f;
    logic       funct_ok;
    f        = {instr[31:25], instr[14:12]};
    funct_ok = (f == dummy_instr_funct(DUMMY_ADD)) ||
               (f == dummy_instr_funct(DUMMY_MUL)) ||
               (f == dummy_instr_funct(DUMMY_DIV)) ||
               (f == dummy_instr_funct(DUMMY_AND));
    return (instr[6:0] == DUMMY_OPCODE) && (instr[11:7] == 5'd0) && funct_ok;
  endfunction

endpackage

// File: rtl/ibex_dummy_instr_checker.sv
// ibex_dummy_instr_checker: retire-side counterpart of the dummy instruction
// inserter. Splits retirements into real and dummy, counts dummies, checks each
// dummy's encoding and checks that the run of real instructions between two
// dummies stays within the configured mask bound (plus pipeline skid).
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   dummy_instr_en_i     CSR: dummy insertion enabled
//   dummy_instr_mask_i   CSR: gap mask (same value the inserter uses)
//   cfg_update_i         pulse on any CSR write to en/mask/seed
//   instr_done_i         an instruction retires this cycle
//   instr_is_dummy_i     the retiring instruction is a dummy
//   instr_rdata_i        encoding of the retiring instruction
//   clear_i              clears dummy_cnt_o and alert_sticky_o
//   instr_retire_o       real retirement (combinational)
//   dummy_retire_o       dummy retirement (combinational)
//   dummy_cnt_o          saturating count of dummy retirements
//   alert_enc_o          1-cycle pulse: illegal dummy encoding
//   alert_gap_o          1-cycle pulse: gap bound exceeded
//   alert_sticky_o       OR of all alerts since reset/clear
module ibex_dummy_instr_checker
  import ibex_pkg::*;
#(
  parameter int unsigned GapSlack  = 2,
  parameter int unsigned DummyCntW = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 dummy_instr_en_i,
  input  logic [2:0]           dummy_instr_mask_i,
  input  logic                 cfg_update_i,
  input  logic                 instr_done_i,
  input  logic                 instr_is_dummy_i,
  input  logic [31:0]          instr_rdata_i,
  input  logic                 clear_i,
  output logic                 instr_retire_o,
  output logic                 dummy_retire_o,
  output logic [DummyCntW-1:0] dummy_cnt_o,
  output logic                 alert_enc_o,
  output logic                 alert_gap_o,
  output logic                 alert_sticky_o
);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_SYNC  = 2'd1,
    S_TRACK = 2'd2
  } dummy_chk_state_e;

  dummy_chk_state_e       state_q, state_d;
  logic [5:0]             gap_q, gap_d;
  logic [5:0]             gap_bound;
  logic                   gap_alert;
  logic                   enc_alert;
  logic [DummyCntW-1:0]   dummy_cnt_q;
  logic                   alert_enc_q, alert_gap_q, sticky_q;

  assign instr_retire_o = instr_done_i & ~instr_is_dummy_i;
  assign dummy_retire_o = instr_done_i &  instr_is_dummy_i;

  // Largest real-instruction run the inserter can produce, plus skid.
  assign gap_bound = {1'b0, dummy_instr_mask_i, 2'b11} + 6'(GapSlack);

  assign enc_alert = dummy_retire_o & ~dummy_instr_legal(instr_rdata_i);

  // NOTE: every signal driven here gets a default first so no path through the
  // case leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    gap_alert = 1'b0;
    unique case (state_q)
      S_OFF: begin
        gap_d = '0;
        if (dummy_instr_en_i) state_d = S_SYNC;
      end
      S_SYNC: begin
        gap_d = '0;
        if (!dummy_instr_en_i)   state_d = S_OFF;
        else if (cfg_update_i)   state_d = S_SYNC;
        else if (dummy_retire_o) state_d = S_TRACK;
      end
      S_TRACK: begin
        if (!dummy_instr_en_i) begin
          state_d = S_OFF;
          gap_d   = '0;
        end else if (cfg_update_i) begin
          // New mask/seed: the running gap no longer means anything.
          state_d = S_SYNC;
          gap_d   = '0;
        end else if (dummy_retire_o) begin
          gap_d = '0;
        end else if (instr_retire_o) begin
          // >= so every retirement past the bound re-pulses.
          gap_alert = (gap_q >= gap_bound);
          gap_d     = (gap_q == 6'd63) ? gap_q : gap_q + 6'd1;
        end
      end
      default: begin
        state_d = S_OFF;
        gap_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_OFF;
      gap_q       <= '0;
      dummy_cnt_q <= '0;
      alert_enc_q <= 1'b0;
      alert_gap_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      alert_enc_q <= enc_alert;
      alert_gap_q <= gap_alert;
      // A pulse present in the clear cycle re-sets the sticky bit.
      sticky_q    <= (sticky_q & ~clear_i) | alert_enc_q | alert_gap_q;
      if (clear_i) begin
        dummy_cnt_q <= dummy_retire_o ? DummyCntW'(1) : '0;
      end else if (dummy_retire_o && (dummy_cnt_q != {DummyCntW{1'b1}})) begin
        dummy_cnt_q <= dummy_cnt_q + DummyCntW'(1);
      end
    end
  end

  assign dummy_cnt_o    = dummy_cnt_q;
  assign alert_enc_o    = alert_enc_q;
  assign alert_gap_o    = alert_gap_q;
  assign alert_sticky_o = sticky_q;

endmodule
